// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressed data memory: opcodes, FSM states,
// access sizes and the wait-counter width.
package mem_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  // Wide enough for LATENCY up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

endpackage

// File: rtl/byte_ram_fmt.sv
// Combinational opcode decode, load-data extension and store lane packing.
// Misalignment detection only exists when MISALIGN_CHECK_EN is defined.
import mem_pkg::*;

module byte_ram_fmt (
  input  logic [5:0]  op,
  input  logic        rw,
  input  logic [1:0]  alo,
  input  logic [31:0] rd_word,
  input  logic [31:0] din,
  output size_t       size,
  output logic        legal,
  output logic        mis,
  output logic [31:0] load_data,
  output logic [31:0] st_word
);

  logic is_signed;
  logic is_read;

  always_comb begin
    size      = SZ_W;
    is_signed = 1'b0;
    is_read   = 1'b1;
    legal     = 1'b1;
    case (op)
      OP_LW:   size = SZ_W;
      OP_LH:   begin size = SZ_H; is_signed = 1'b1; end
      OP_LHU:  size = SZ_H;
      OP_LB:   begin size = SZ_B; is_signed = 1'b1; end
      OP_LBU:  size = SZ_B;
      OP_SW:   begin size = SZ_W; is_read = 1'b0; end
      OP_SH:   begin size = SZ_H; is_read = 1'b0; end
      OP_SB:   begin size = SZ_B; is_read = 1'b0; end
      default: legal = 1'b0;
    endcase
    // A load opcode issued as a write (or vice versa) is treated as unknown.
    if (is_read != rw) legal = 1'b0;
  end

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    mis = 1'b0;
    if (legal) begin
      if (size == SZ_W && alo != 2'b00) mis = 1'b1;
      if (size == SZ_H && alo[0])       mis = 1'b1;
    end
  end
`else
  logic unused_alo;
  assign unused_alo = ^alo;
  assign mis        = 1'b0;
`endif

  // rd_word holds Mem[a..a+3] big-endian, so narrow loads take the top bytes.
  always_comb begin
    load_data = rd_word;
    st_word   = din;
    case (size)
      SZ_B: begin
        load_data = {{24{is_signed & rd_word[31]}}, rd_word[31:24]};
        st_word   = {din[7:0], 24'h0};
      end
      SZ_H: begin
        load_data = {{16{is_signed & rd_word[31]}}, rd_word[31:16]};
        st_word   = {din[15:0], 16'h0};
      end
      default: begin
        load_data = rd_word;
        st_word   = din;
      end
    endcase
  end

endmodule

// File: rtl/byte_ram_ctrl.sv
// Clocked big-endian byte RAM behind a MOV/MOC handshake with programmable latency.
// Optional macro MISALIGN_CHECK_EN enables ERR for unknown opcodes and misaligned accesses.
import mem_pkg::*;

module byte_ram_ctrl #(
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MOV,
  input  logic              ReadWrite,
  input  logic [5:0]        OP,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              ERR,
  output state_t            dbg_state
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: the requester raises MOV with the request fields and holds it
  // until MOC=1; dropping MOV before MOC aborts with no side effects. After MOC,
  // MOV low for one cycle releases MOC and re-arms the controller.

  logic [7:0]       mem [DEPTH];
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    a_q;
  logic [5:0]       op_q;
  logic             rw_q;
  logic [31:0]      din_q;
  logic [31:0]      dout_q;
  logic             moc_q;

  logic [AW-1:0]    a1, a2, a3;
  logic [31:0]      rd_word;
  logic [31:0]      load_data;
  logic [31:0]      st_word;
  size_t            size;
  logic             legal;
  logic             mis;
  logic             access;
  logic             we;

  logic unused_addr;
  assign unused_addr = ^Address[ADDR_W-1:AW];

  // Multi-byte accesses wrap naturally in AW-bit index arithmetic.
  assign a1      = a_q + AW'(1);
  assign a2      = a_q + AW'(2);
  assign a3      = a_q + AW'(3);
  assign rd_word = {mem[a_q], mem[a1], mem[a2], mem[a3]};

  byte_ram_fmt u_fmt (
    .op        (op_q),
    .rw        (rw_q),
    .alo       (a_q[1:0]),
    .rd_word   (rd_word),
    .din       (din_q),
    .size      (size),
    .legal     (legal),
    .mis       (mis),
    .load_data (load_data),
    .st_word   (st_word)
  );

  assign access = (state == S_BUSY) && MOV && (cnt == '0);
  assign we     = access && legal && !mis && !rw_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[a_q] <= st_word[31:24];
      if (size != SZ_B) mem[a1] <= st_word[23:16];
      if (size == SZ_W) begin
        mem[a2] <= st_word[15:8];
        mem[a3] <= st_word[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      op_q   <= '0;
      rw_q   <= 1'b0;
      din_q  <= '0;
      dout_q <= '0;
      moc_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          moc_q <= 1'b0;
          if (MOV) begin
            a_q   <= Address[AW-1:0];
            op_q  <= OP;
            rw_q  <= ReadWrite;
            din_q <= DataIn;
            cnt   <= CNT_W'(LATENCY);
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!MOV) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            if (mis)                dout_q <= '0;
            else if (legal && rw_q) dout_q <= load_data;
            state <= S_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          // MOC rises on the cycle after the access, once the result is settled.
          if (!MOV) begin
            moc_q <= 1'b0;
            state <= S_IDLE;
          end else begin
            moc_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && MOV) begin
      err_q <= 1'b0;
    end else if (access) begin
      err_q <= !legal || mis;
    end
  end
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign DataOut   = dout_q;
  assign MOC       = moc_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_byte_ram_ctrl.sv
// Randomized and directed bench for byte_ram_ctrl against a byte-array reference
// model; honours MISALIGN_CHECK_EN when it is defined for the build.
import mem_pkg::*;

module tb_byte_ram_ctrl;

  localparam int DEPTH = 512;
  localparam int AWID  = 32;
  localparam int LAT   = 2;

  logic            clk;
  logic            rst_n;
  logic            mov;
  logic            read_write;
  logic [5:0]      op;
  logic [AWID-1:0] address;
  logic [31:0]     data_in;
  logic [31:0]     data_out;
  logic            moc;
  logic            err;
  state_t          dbg_state;

  byte_ram_ctrl #(.DEPTH(DEPTH), .ADDR_W(AWID), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MOV       (mov),
    .ReadWrite (read_write),
    .OP        (op),
    .Address   (address),
    .DataIn    (data_in),
    .DataOut   (data_out),
    .MOC       (moc),
    .ERR       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard
  logic [7:0]  m_mem [DEPTH];
  logic [31:0] m_dout;
  logic [31:0] exp_q[$];
  logic [31:0] exp_err_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: derive size/sign/direction from the opcode table, then act on bytes.
  task automatic model_access(input logic rw, input logic [5:0] o, input logic [31:0] a,
                              input logic [31:0] d);
    int          nb;
    bit          sgn, rd, ok, e;
    logic [31:0] v;
    int unsigned idx;
    nb = 4; sgn = 0; rd = 1; ok = 1; e = 0;
    case (o)
      6'b100011: nb = 4;
      6'b100001: begin nb = 2; sgn = 1; end
      6'b100101: nb = 2;
      6'b100000: begin nb = 1; sgn = 1; end
      6'b100100: nb = 1;
      6'b101011: begin nb = 4; rd = 0; end
      6'b101001: begin nb = 2; rd = 0; end
      6'b101000: begin nb = 1; rd = 0; end
      default:   ok = 0;
    endcase
    if (rd != rw) ok = 0;
`ifdef MISALIGN_CHECK_EN
    if (!ok) e = 1;
    else if ((nb == 4 && a[1:0] != 2'b00) || (nb == 2 && a[0])) begin
      e = 1; ok = 0; m_dout = 32'h0;
    end
`endif
    if (ok) begin
      if (rd) begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) begin
          idx = (a + 32'(i)) % DEPTH;
          v = (v << 8) | {24'h0, m_mem[idx]};
        end
        if (sgn && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sgn && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
        m_dout = v;
      end else begin
        for (int i = 0; i < nb; i++) begin
          idx = (a + 32'(i)) % DEPTH;
          m_mem[idx] = d[8*(nb-1-i) +: 8];
        end
      end
    end
    exp_q.push_back(m_dout);
    exp_err_q.push_back({31'h0, e});
  endtask

  // driver tasks: entered and left #1 after a rising edge
  task automatic start_req(input logic rw, input logic [5:0] o, input logic [31:0] a,
                           input logic [31:0] d);
    mov = 1'b1; read_write = rw; op = o; address = a; data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic wait_moc(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (moc) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int lat);
    logic [31:0] ed, ee;
    ed = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    check({tag, "_lat"}, 32'(lat), 32'(LAT + 2));
    check({tag, "_dout"}, data_out, ed);
    check({tag, "_err"}, {31'h0, err}, ee);
  endtask

  task automatic do_req(input string tag, input logic rw, input logic [5:0] o,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
    int lat;
    model_access(rw, o, a, d);
    start_req(rw, o, a, d);
    wait_moc(lat);
    got = data_out;
    check_result(tag, lat);
    mov = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [5:0] op_tab [9];
  logic [31:0] got;
  int          lat;
  int          moc_seen;

  initial begin
    op_tab = '{6'b100011, 6'b100001, 6'b100101, 6'b100000, 6'b100100,
               6'b101011, 6'b101001, 6'b101000, 6'b111111};
    m_dout = 32'h0;
    rst_n = 1'b0; mov = 1'b0; read_write = 1'b1; op = 6'h0; address = '0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", data_out, 32'h0);
    check("reset_moc", {31'h0, moc}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    rst_n = 1'b1;
    moc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (moc || dbg_state != S_IDLE) moc_seen++;
    end
    check("idle_10", 32'(moc_seen), 32'h0);

    // Fill the array so every later read has a known value.
    for (int w = 0; w < DEPTH / 4; w++)
      do_req("init", 1'b0, OP_SW, 32'(w * 4), $urandom, got);

    do_req("sw10", 1'b0, OP_SW, 32'h10, 32'hDEAD_BEEF, got);
    do_req("lw10", 1'b1, OP_LW, 32'h10, 32'h0, got);
    check("lw10_lit", got, 32'hDEAD_BEEF);
    do_req("lbu11", 1'b1, OP_LBU, 32'h11, 32'h0, got);
    check("lbu11_lit", got, 32'h0000_00AD);

    do_req("sb20", 1'b0, OP_SB, 32'h20, 32'h80, got);
    do_req("sb21", 1'b0, OP_SB, 32'h21, 32'h01, got);
    do_req("lb20", 1'b1, OP_LB, 32'h20, 32'h0, got);
    check("lb20_lit", got, 32'hFFFF_FF80);
    do_req("lh20", 1'b1, OP_LH, 32'h20, 32'h0, got);
    check("lh20_lit", got, 32'hFFFF_8001);
    do_req("lhu20", 1'b1, OP_LHU, 32'h20, 32'h0, got);
    check("lhu20_lit", got, 32'h0000_8001);

    // Wrap across the top of the array.
    do_req("sw_wrap", 1'b0, OP_SW, 32'(DEPTH - 2), 32'h1122_3344, got);
    do_req("lbu_top", 1'b1, OP_LBU, 32'(DEPTH - 1), 32'h0, got);
    do_req("lbu_0", 1'b1, OP_LBU, 32'h0, 32'h0, got);
    do_req("lbu_1", 1'b1, OP_LBU, 32'h1, 32'h0, got);
    do_req("bad_op", 1'b1, 6'b111111, 32'h4, 32'h0, got);
    do_req("mism_rw", 1'b0, OP_LW, 32'h4, 32'hFFFF_FFFF, got);

    // Abort in BUSY: no write, no MOC.
    start_req(1'b0, OP_SW, 32'h30, 32'hCAFE_F00D);
    @(posedge clk); #1;
    mov = 1'b0;
    moc_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (moc) moc_seen++;
    end
    check("abort_moc", 32'(moc_seen), 32'h0);
    do_req("abort_lw30", 1'b1, OP_LW, 32'h30, 32'h0, got);

    // Reset while in DONE.
    model_access(1'b1, OP_LW, 32'h10, 32'h0);
    start_req(1'b1, OP_LW, 32'h10, 32'h0);
    wait_moc(lat);
    check_result("pre_rst", lat);
    rst_n = 1'b0;
    #1;
    check("rst_done_moc", {31'h0, moc}, 32'h0);
    check("rst_done_dout", data_out, 32'h0);
    m_dout = 32'h0;
    mov = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req("post_rst_lw10", 1'b1, OP_LW, 32'h10, 32'h0, got);
    check("post_rst_lit", got, 32'hDEAD_BEEF);

    // Hold MOV after MOC: no second access.
    model_access(1'b0, OP_SB, 32'h40, 32'h5A);
    start_req(1'b0, OP_SB, 32'h40, 32'h5A);
    wait_moc(lat);
    check_result("hold", lat);
    moc_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!moc || dbg_state != S_DONE) moc_seen++;
    end
    check("hold_stable", 32'(moc_seen), 32'h0);
    mov = 1'b0;
    @(posedge clk); #1;
    do_req("after_hold", 1'b1, OP_LBU, 32'h40, 32'h0, got);

    // Random traffic.
    for (int t = 0; t < 200; t++) begin
      logic        rw;
      logic [5:0]  o;
      logic [31:0] a;
      o  = op_tab[$urandom_range(0, 8)];
      rw = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) == 1) : ~o[3];
      a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
      do_req("rnd", rw, o, a, $urandom, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
